// File: rtl/mem_pkg.sv
// mem_pkg: shared block geometry, reader state encoding and block type
//
// Also usable by the block-to-memory writer.
//   BLOCK_DIM / BLOCK_WORDS : 8x8 block, 64 words
//   MEM_DATA_W              : default coefficient word width
//   rd_state_e              : reader FSM states
//   block_t                 : packed 8x8 array of MEM_DATA_W words, [row][col]
package mem_pkg;

    localparam int BLOCK_DIM   = 8;
    localparam int BLOCK_WORDS = BLOCK_DIM * BLOCK_DIM;
    localparam int MEM_DATA_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CAPTURE,
        VALID
    } rd_state_e;

    typedef logic [BLOCK_DIM-1:0][BLOCK_DIM-1:0][MEM_DATA_W-1:0] block_t;

endpackage

// File: rtl/mem_block_reader.sv
// mem_block_reader: fetch one 8x8 block of words from synchronous-read memory
//
// Block k occupies words k*64 .. k*64+63, row-major. Word n is captured into
// output_data_array[n/8][n%8]; with MEM_BLOCK_READER_TRANSPOSE_EN defined it
// goes to [n%8][n/8] instead. Timing and addresses are identical in both builds.
//
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   start, block_index  : block request, sampled in IDLE or in VALID with out_ready
//   busy                : high in READ, CAPTURE and VALID
//   mem_rd_en/addr      : registered memory read strobe and address
//   mem_rd_data         : memory data, one cycle after the address is sampled
//   output_data_array   : assembled block, [row][col]
//   out_valid/out_ready : block handshake
module mem_block_reader
    import mem_pkg::*;
#(
    parameter int MEM_DEPTH = 2048,
    parameter int DATA_W    = 32,
    parameter int BLK_IDX_W = $clog2(MEM_DEPTH / 64),
    parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          start,
    input  logic [BLK_IDX_W-1:0]                          block_index,
    output logic                                          busy,
    output logic                                          mem_rd_en,
    output logic [ADDR_W-1:0]                             mem_rd_addr,
    input  logic [DATA_W-1:0]                             mem_rd_data,
    output logic [BLOCK_DIM-1:0][BLOCK_DIM-1:0][DATA_W-1:0] output_data_array,
    output logic                                          out_valid,
    input  logic                                          out_ready
);

    rd_state_e state_q, state_d;
    logic [BLK_IDX_W-1:0] blk_q, blk_d;
    logic [5:0] cnt_q, cnt_d;
    logic en_q, en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic cap_vld_q;
    logic [5:0] cap_idx_q;
    logic [2:0] cap_row, cap_col;
    logic [BLOCK_DIM-1:0][BLOCK_DIM-1:0][DATA_W-1:0] arr_q;

`ifdef MEM_BLOCK_READER_TRANSPOSE_EN
    assign cap_row = cap_idx_q[2:0];
    assign cap_col = cap_idx_q[5:3];
`else
    assign cap_row = cap_idx_q[5:3];
    assign cap_col = cap_idx_q[2:0];
`endif

    // cnt_q is the index of the word whose address is currently driven, so
    // base+cnt is simply the block index concatenated with the counter.
    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        cnt_d   = cnt_q;
        en_d    = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = READ;
                blk_d   = block_index;
                cnt_d   = '0;
                en_d    = 1'b1;
            end
            READ: if (cnt_q == 6'(BLOCK_WORDS - 1)) begin
                state_d = CAPTURE;
            end else begin
                cnt_d = cnt_q + 6'd1;
                en_d  = 1'b1;
            end
            CAPTURE: state_d = VALID;
            VALID: if (out_ready) begin
                state_d = start ? READ : IDLE;
                blk_d   = start ? block_index : blk_q;
                cnt_d   = start ? 6'd0 : cnt_q;
                en_d    = start;
            end
            default: state_d = IDLE;
        endcase
        addr_d = en_d ? {blk_d, cnt_d} : addr_q;
    end

    // The capture-valid delay resets too, so data in flight at reset is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            blk_q     <= '0;
            cnt_q     <= '0;
            en_q      <= 1'b0;
            addr_q    <= '0;
            cap_vld_q <= 1'b0;
            cap_idx_q <= '0;
            arr_q     <= '0;
        end else begin
            state_q   <= state_d;
            blk_q     <= blk_d;
            cnt_q     <= cnt_d;
            en_q      <= en_d;
            addr_q    <= addr_d;
            cap_vld_q <= en_q;
            cap_idx_q <= cnt_q;
            if (cap_vld_q) arr_q[cap_row][cap_col] <= mem_rd_data;
        end
    end

    assign busy              = (state_q != IDLE);
    assign out_valid         = (state_q == VALID);
    assign mem_rd_en         = en_q;
    assign mem_rd_addr       = addr_q;
    assign output_data_array = arr_q;

endmodule

// File: tb/tb_mem_block_reader.sv
// tb_mem_block_reader: directed self-checking bench for mem_block_reader
module tb_mem_block_reader;

    logic clock = 1'b0;
    logic reset;
    logic start;
    logic [4:0] block_index;
    logic busy;
    logic mem_rd_en;
    logic [10:0] mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic [7:0][7:0][31:0] arr;
    logic out_valid;
    logic out_ready;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [2048];

    mem_block_reader dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .block_index(block_index),
        .busy(busy),
        .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .output_data_array(arr),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clock = ~clock;

    initial for (int a = 0; a < 2048; a++) mem[a] = 32'(a);

    always @(posedge clock) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Expected content of element [r][c] for block blk (memory word[a] = a).
    function automatic logic [31:0] exp_word(input int blk, input int r, input int c);
`ifdef MEM_BLOCK_READER_TRANSPOSE_EN
        return 32'(blk * 64 + c * 8 + r);
`else
        return 32'(blk * 64 + r * 8 + c);
`endif
    endfunction

    task automatic check_block(input string name, input int blk);
        int bad = 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (arr[r][c] !== exp_word(blk, r, c)) begin
                    if (bad == 0)
                        $display("FAIL %s [%0d][%0d] got %0d expected %0d", name, r, c, arr[r][c], exp_word(blk, r, c));
                    bad++;
                end
        checks++;
        if (bad != 0) errors++;
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (arr !== '0) begin
            errors++;
            $display("FAIL %s array not all zero, [0][0]=%0d [7][7]=%0d", name, arr[0][0], arr[7][7]);
        end
    endtask

    task automatic run_read(input logic [4:0] idx);
        int n = 0;
        start = 1'b1;
        block_index = idx;
        step();
        start = 1'b0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (n != 65) begin
            errors++;
            $display("FAIL run_read latency got %0d cycles expected 65", n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; block_index = '0; out_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        checks++;
        if ({busy, mem_rd_en, out_valid} !== 3'b000 || mem_rd_addr !== 11'd0) begin
            errors++;
            $display("FAIL reset busy/en/valid got %b addr %0d expected 000 addr 0", {busy, mem_rd_en, out_valid}, mem_rd_addr);
        end
        check_zero("reset_array");
    endtask

    // Block 3 read, with an ignored start (block 5) pulsed mid-READ.
    task automatic test_read_block3();
        int bad = 0;
        start = 1'b1; block_index = 5'd3;
        step();
        start = 1'b0;
        for (int n = 0; n < 64; n++) begin
            if (mem_rd_en !== 1'b1 || mem_rd_addr !== 11'(192 + n) || busy !== 1'b1 || out_valid !== 1'b0) begin
                if (bad == 0)
                    $display("FAIL read3 cycle %0d en %b addr %0d busy %b valid %b expected 1 %0d 1 0", n, mem_rd_en, mem_rd_addr, busy, out_valid, 192 + n);
                bad++;
            end
            start = (n == 10); block_index = (n == 10) ? 5'd5 : 5'd3;
            step();
        end
        start = 1'b0;
        checks++;
        if (bad != 0) errors++;
        checks++;
        if (mem_rd_en !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL capture_cycle en %b valid %b busy %b expected 0 0 1", mem_rd_en, out_valid, busy);
        end
        step();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL valid_at_65 got %b expected 1", out_valid);
        end
        checks++;
        if (arr[0][0] !== 32'd192 || arr[7][7] !== 32'd255) begin
            errors++;
            $display("FAIL read3_corners got %0d %0d expected 192 255", arr[0][0], arr[7][7]);
        end
        checks++;
`ifdef MEM_BLOCK_READER_TRANSPOSE_EN
        if (arr[5][2] !== 32'd213 || arr[0][7] !== 32'd248) begin
            errors++;
            $display("FAIL read3_transpose got %0d %0d expected 213 248", arr[5][2], arr[0][7]);
        end
`else
        if (arr[2][5] !== 32'd213) begin
            errors++;
            $display("FAIL read3_elem25 got %0d expected 213", arr[2][5]);
        end
`endif
        check_block("read3_full", 3);
    endtask

    task automatic test_hold_and_release();
        int bad = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid !== 1'b1 || busy !== 1'b1 || arr[7][7] !== 32'd255 || arr[0][0] !== 32'd192) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold valid %b [7][7] %0d over %0d bad cycles expected 1 255", out_valid, arr[7][7], bad);
        end
        check_block("hold_full", 3);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL release busy %b valid %b en %b expected 0 0 0", busy, out_valid, mem_rd_en);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_stays busy got %b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        run_read(5'd3);
        start = 1'b1; block_index = 5'd31; out_ready = 1'b1;
        step();
        start = 1'b0; out_ready = 1'b0;
        checks++;
        if (mem_rd_en !== 1'b1 || mem_rd_addr !== 11'd1984 || busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first en %b addr %0d busy %b valid %b expected 1 1984 1 0", mem_rd_en, mem_rd_addr, busy, out_valid);
        end
        for (int i = 0; i < 64; i++) step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_early valid got %b expected 0", out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || arr[7][7] !== 32'd2047 || arr[0][0] !== 32'd1984) begin
            errors++;
            $display("FAIL b2b_valid valid %b [0][0] %0d [7][7] %0d expected 1 1984 2047", out_valid, arr[0][0], arr[7][7]);
        end
        check_block("b2b_full", 31);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        start = 1'b1; block_index = 5'd3;
        step();
        start = 1'b0;
        for (int i = 0; i < 29; i++) step();
        checks++;
        if (mem_rd_addr !== 11'd221 || mem_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_read addr %0d en %b expected 221 1", mem_rd_addr, mem_rd_en);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (mem_rd_en !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || mem_rd_addr !== 11'd0) begin
            errors++;
            $display("FAIL mid_reset en %b valid %b busy %b addr %0d expected 0 0 0 0", mem_rd_en, out_valid, busy, mem_rd_addr);
        end
        check_zero("mid_reset_array");
        step(); step();
        check_zero("mid_reset_pending");
        run_read(5'd0);
        checks++;
        if (arr[0][0] !== 32'd0 || arr[7][7] !== 32'd63) begin
            errors++;
            $display("FAIL blk0_corners got %0d %0d expected 0 63", arr[0][0], arr[7][7]);
        end
        check_block("blk0_full", 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_block3();
        test_hold_and_release();
        test_back_to_back();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
